vc_plane_receiver: RTL

Receive-side counterpart of the VC plane controller. A single shared input link carries one flit per cycle belonging to whichever VC plane the plane selector currently names. This block steers each accepted flit into a per-VC FIFO for that plane and presents each FIFO to the router core through an independent valid/ready read port. Backpressure on the shared link is per plane: the block is ready only when the currently selected plane's FIFO has space.

---
 rtl/vc_plane_receiver_pkg.sv | 18 +
 rtl/vc_plane_fifo.sv | 71 +++++++
 rtl/vc_plane_receiver.sv | 70 +++++++
 3 files changed

// File: rtl/vc_plane_receiver_pkg.sv
// Shared definitions for the VC plane controller, receiver and switch logic.
package vc_plane_receiver_pkg;

    typedef int unsigned plane_idx_t;

    function automatic int sel_width(input int vc);
        return vc + 1;
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic plane_is_legal(input plane_idx_t sel, input int vc);
        return sel < plane_idx_t'(vc);
    endfunction

endpackage

// File: rtl/vc_plane_fifo.sv
// Single-clock synchronous FIFO; the head entry is always visible on head_data.
import vc_plane_receiver_pkg::*;

module vc_plane_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         head_data,
    output logic                          full,
    output logic                          empty,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic                  do_push, do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head is read straight from the array so a new flit is visible one cycle after its write.
    assign head_data = mem[rd_ptr_reg];

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (do_push) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/vc_plane_receiver.sv
// Steers flits from the shared link into per-VC FIFOs and exposes each FIFO as its own read port.
import vc_plane_receiver_pkg::*;

module vc_plane_receiver #(
    parameter int VC         = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [VC:0]              VCPlaneSelector,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     valid_in,
    output logic                     ready_in,
    output logic [VC*DATA_WIDTH-1:0] data_out,
    output logic [VC-1:0]            valid_out,
    input  logic [VC-1:0]            ready_out,
    output logic                     plane_error
);

    localparam int SEL_W = sel_width(VC);
    localparam int CNT_W = count_width(DEPTH);

    logic [VC-1:0] sel_match;
    logic [VC-1:0] fifo_full;
    logic [VC-1:0] fifo_empty;
    logic [VC-1:0] push_en;
    logic [VC-1:0] pop_en;
    logic          sel_legal;
    logic          plane_error_reg;
    // Occupancy is only observed for debug; the read/write decisions use full/empty.
    logic [CNT_W-1:0] fifo_count_unused [VC];

    assign sel_legal   = plane_is_legal(plane_idx_t'(VCPlaneSelector), VC);
    assign ready_in    = sel_legal && |(sel_match & ~fifo_full);
    assign valid_out   = ~fifo_empty;
    assign plane_error = plane_error_reg;

    generate
        for (genvar gi = 0; gi < VC; gi++) begin : g_plane
            assign sel_match[gi] = (VCPlaneSelector == SEL_W'(gi));
            assign push_en[gi]   = valid_in && sel_legal && sel_match[gi] && !fifo_full[gi];
            assign pop_en[gi]    = ready_out[gi] && !fifo_empty[gi];

            vc_plane_fifo #(
                .DATA_WIDTH(DATA_WIDTH),
                .DEPTH     (DEPTH)
            ) u_fifo (
                .clk      (clk),
                .rst      (rst),
                .push     (push_en[gi]),
                .push_data(data_in),
                .pop      (pop_en[gi]),
                .head_data(data_out[gi*DATA_WIDTH +: DATA_WIDTH]),
                .full     (fifo_full[gi]),
                .empty    (fifo_empty[gi]),
                .count    (fifo_count_unused[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            plane_error_reg <= 1'b0;
        end else if (valid_in && !sel_legal) begin
            plane_error_reg <= 1'b1;
        end
    end

endmodule
